aes_sel_gen: RTL
================

Name: aes_sel_gen

Overview:
- Transmit-side counterpart of the AES sparse mux-select buffer/checker.
- Accepts a binary mux index over a valid/ready handshake and drives the matching sparse (Hamming-distance-protected) select word from a register.
- Holds the select word stable for a programmable number of cycles.
- On any fault, enters a terminal error state and drives an all-zero select word; all-zero is illegal for every supported Num, so downstream select checkers also flag it.

Parameters:
- Num, 2, number of mux inputs; supported values 2, 3, 4, 6.
- Width, 3, select width; must be 3 for Num=2, 5 for Num=3/4, 6 for Num=6.
- HoldCycles, 1, cycles the select is held busy after acceptance; range 1..15.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  request valid
- idx_i  input  3  binary mux index, legal range 0..Num-1
- ready_o  output  1  generator can accept a request
- sel_o  output  Width  registered sparse select word
- err_o  output  1  sticky fault flag

Behaviour:
- Reset: one clock, asynchronous active-low reset, as in the interface. While reset is asserted: state=IDLE, sel_o=enc(0), ready_o=1, err_o=0, hold counter=0.
- Encoding enc(i):
  - Num=2: 011, 100.
  - Num=3: 01110, 11000, 00001.
  - Num=4: the Num=3 words, then 10111.
  - Num=6: 011101, 110000, 001000, 000011, 111110, 100101.
- FSM states: IDLE, HOLD, ERROR. ready_o=1 only in IDLE.
- IDLE:
  - req_i=1 and idx_i<Num: next edge sel_o<=enc(idx_i), counter<=HoldCycles-1, state<=HOLD.
  - req_i=1 and idx_i>=Num: next edge state<=ERROR.
  - req_i=0: sel_o holds its last value.
- HOLD:
  - req_i is ignored and not queued; the requester must keep req_i asserted until ready_o=1.
  - counter==0: next state IDLE. Otherwise counter decrements.
  - ready_o is therefore low for exactly HoldCycles cycles after the accept edge.
  - Latency: the accept edge is also the sel_o update edge; sel_o is valid in the cycle after acceptance.
- ERROR:
  - Terminal; only reset exits.
  - sel_o<=0 on the entry edge and after; err_o=1 from the entry edge; ready_o=0.
- Unsupported Num, or Width not matching Num:
  - err_o=1 constantly, including during reset; sel_o=0; ready_o=0.
  - The FSM is never exercised.
- Illegal FSM state encoding (e.g. upset): treated as ERROR.
- Reset asserted mid-HOLD: immediately IDLE, sel_o=enc(0), ready_o=1.
- Request arriving in the same cycle the counter reaches 0: not accepted; accepted in the following IDLE cycle if still asserted.
- sel_o is never combinationally derived from idx_i; it always comes straight from flops.

Optional Feature:
- Macro: AES_SEL_GEN_SELF_CHK_EN.
- Defined:
  - Every cycle, registered sel_o is compared against the legal set for Num.
  - Outside ERROR state, any mismatch (e.g. a flop upset) causes entry to ERROR on the next edge: err_o=1, sel_o=0.
  - The check is disabled during reset.
- Undefined:
  - No self-check logic.
  - err_o is raised only by an out-of-range idx_i, an illegal FSM state, or unsupported parameters.

Test Plan:
- Num=3, Width=5, HoldCycles=1; reset released; req_i=1, idx_i=2 -> next cycle sel_o=00001, ready_o=0 for 1 cycle, then ready_o=1; err_o=0.
- Num=6, Width=6, HoldCycles=4; accept idx_i=4 -> sel_o=111110, ready_o low exactly 4 cycles; req_i held with idx_i=1 during HOLD -> accepted on the first IDLE cycle, sel_o=110000 on the following cycle.
- Num=4, Width=5; req_i=1, idx_i=5 -> next cycle err_o=1, sel_o=00000, ready_o=0; later valid requests are ignored; rst_ni low -> sel_o=01110, err_o=0.
- Num=2, Width=3, HoldCycles=3; accept idx_i=1 (sel_o=100); assert rst_ni=0 mid-HOLD -> asynchronously sel_o=011, ready_o=1, err_o=0.
- Num=4, Width=6 (mismatch) -> err_o=1 and sel_o=000000 throughout, including reset; req_i never accepted.
- With AES_SEL_GEN_SELF_CHK_EN; Num=2; force the sel_o flop to 111 for one cycle while in IDLE -> next edge err_o=1, sel_o=000. Without the macro: the same force leaves err_o=0.

Source files
------------

// File: rtl/aes_sel_gen.sv
// Sparse mux-select generator: takes a binary index over valid/ready, drives a registered
// Hamming-protected select word, holds it busy, and falls into a terminal all-zero error state.
// Optional macro AES_SEL_GEN_SELF_CHK_EN adds a per-cycle legality check of the select register.
module aes_sel_gen #(
    parameter int Num        = 2,
    parameter int Width      = 3,
    parameter int HoldCycles = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [2:0]       idx_i,
    output logic             ready_o,
    output logic [Width-1:0] sel_o,
    output logic             err_o
);

    localparam bit CfgOk = (Num == 2 && Width == 3) ||
                           ((Num == 3 || Num == 4) && Width == 5) ||
                           (Num == 6 && Width == 6);
    localparam logic [3:0] NumIdx   = 4'(Num);
    localparam logic [3:0] HoldLast = 4'(HoldCycles - 1);

    // Handshake: a request transfers on a clock edge where req_i && ready_o; req_i is not
    // queued while busy, so the requester keeps it asserted until ready_o returns.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic [Width-1:0] sel_q;
    logic             accept;
    logic             idx_ok;

    function automatic logic [Width-1:0] enc(input logic [2:0] i);
        logic [5:0] w;
        w = '0;
        case (Num)
            2: w = (i == 3'd0) ? 6'b000011 : 6'b000100;
            3, 4: begin
                case (i)
                    3'd0:    w = 6'b001110;
                    3'd1:    w = 6'b011000;
                    3'd2:    w = 6'b000001;
                    3'd3:    w = 6'b010111;
                    default: w = '0;
                endcase
            end
            6: begin
                case (i)
                    3'd0:    w = 6'b011101;
                    3'd1:    w = 6'b110000;
                    3'd2:    w = 6'b001000;
                    3'd3:    w = 6'b000011;
                    3'd4:    w = 6'b111110;
                    3'd5:    w = 6'b100101;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return Width'(w);
    endfunction

    assign idx_ok = ({1'b0, idx_i} < NumIdx);

`ifdef AES_SEL_GEN_SELF_CHK_EN
    logic sel_legal;
    always_comb begin
        sel_legal = 1'b0;
        for (int k = 0; k < Num; k++) begin
            if (sel_q == enc(3'(k))) sel_legal = 1'b1;
        end
    end
`endif

    // State register and select/counter datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= enc(3'd0);
        end else begin
            state_q <= state_d;
            if (state_d == ERROR) begin
                sel_q <= '0;
            end else if (accept) begin
                sel_q <= enc(idx_i);
                cnt_q <= HoldLast;
            end else if (state_q == HOLD && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Next-state logic; any unknown encoding collapses into ERROR
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (idx_ok) begin
                        state_d = HOLD;
                        accept  = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            HOLD:    if (cnt_q == 4'd0) state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
`ifdef AES_SEL_GEN_SELF_CHK_EN
        if ((state_q == IDLE || state_q == HOLD) && !sel_legal) begin
            state_d = ERROR;
            accept  = 1'b0;
        end
`endif
        if (!CfgOk) begin
            state_d = IDLE;
            accept  = 1'b0;
        end
    end

    // Outputs; a bad parameter set pins the block in its fault presentation
    always_comb begin
        ready_o = CfgOk && (state_q == IDLE);
        err_o   = !CfgOk || !(state_q == IDLE || state_q == HOLD);
        sel_o   = CfgOk ? sel_q : '0;
    end

endmodule
